// File: rtl/serial_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : serial_arbiter
//  Purpose  : Two-port arbiter for a shared UART byte channel. It grants
//             ownership per burst and masks the non-owner's handshake.
//  Options  : SERIAL_ARB_STATS_EN adds per-port 16-bit grant counters.
//  Revision : 1.0  initial release
// ============================================================================
module serial_arbiter #(
   parameter int IDLE_RELEASE = 4,
   parameter int MAX_TENURE   = 64,
   parameter int CNT_W        = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req0_rden,
   input  logic       req0_wren,
   input  logic [7:0] req0_wdata,
   output logic [7:0] req0_rdata,
   output logic       req0_valid,
   output logic       req0_ready,
   input  logic       req1_rden,
   input  logic       req1_wren,
   input  logic [7:0] req1_wdata,
   output logic [7:0] req1_rdata,
   output logic       req1_valid,
   output logic       req1_ready,
   input  logic [7:0] uart_rx_data,
   input  logic       uart_rx_valid,
   output logic       uart_rx_rden,
   input  logic       uart_tx_ready,
   output logic [7:0] uart_tx_data,
   output logic       uart_tx_wren
`ifdef SERIAL_ARB_STATS_EN
   ,
   output logic [15:0] grant_count0,
   output logic [15:0] grant_count1
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_idle_last   = CNT_W'(IDLE_RELEASE - 1);
   localparam logic [CNT_W-1:0] c_tenure_last = CNT_W'(MAX_TENURE - 1);
   localparam logic [CNT_W-1:0] c_tenure_max  = CNT_W'(MAX_TENURE);

   state_t           r_state;
   state_t           w_next_state;
   logic             r_last_owner;
   logic [CNT_W-1:0] r_idle_cnt;
   logic [CNT_W-1:0] r_tenure_cnt;

   logic w_req0;
   logic w_req1;
   logic w_own_strobe;
   logic w_other_req;
   logic w_release;
   logic w_grant0;
   logic w_grant1;

   assign w_req0 = req0_rden | req0_wren;
   assign w_req1 = req1_rden | req1_wren;

   always_comb begin
      w_own_strobe = 1'b0;
      w_other_req  = 1'b0;
      case (r_state)
         OWN0: begin
            w_own_strobe = w_req0;
            w_other_req  = w_req1;
         end
         OWN1: begin
            w_own_strobe = w_req1;
            w_other_req  = w_req0;
         end
         default: begin
            w_own_strobe = 1'b0;
            w_other_req  = 1'b0;
         end
      endcase
   end

   // Quiet owner or a starved challenger ends the burst; the strobe in the
   // release cycle itself is still forwarded by the output decode.
   assign w_release = (r_state != IDLE) &&
                      (((r_idle_cnt == c_idle_last) && !w_own_strobe) ||
                       (w_other_req && (r_tenure_cnt >= c_tenure_last)));

   always_comb begin
      w_next_state = r_state;
      w_grant0     = 1'b0;
      w_grant1     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req0 && w_req1) begin
               w_grant0 = r_last_owner;
               w_grant1 = ~r_last_owner;
            end else begin
               w_grant0 = w_req0;
               w_grant1 = w_req1;
            end
         end
         OWN0: begin
            if (w_release) begin
               if (w_req1) begin
                  w_grant1 = 1'b1;
               end else begin
                  w_next_state = IDLE;
               end
            end
         end
         OWN1: begin
            if (w_release) begin
               if (w_req0) begin
                  w_grant0 = 1'b1;
               end else begin
                  w_next_state = IDLE;
               end
            end
         end
         default: w_next_state = IDLE;
      endcase
      if (w_grant0) begin
         w_next_state = OWN0;
      end else if (w_grant1) begin
         w_next_state = OWN1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_last_owner <= 1'b1;
         r_idle_cnt   <= '0;
         r_tenure_cnt <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_grant0 || w_grant1) begin
            r_idle_cnt   <= '0;
            r_tenure_cnt <= '0;
            r_last_owner <= w_grant1;
         end else if (w_next_state == IDLE) begin
            r_idle_cnt   <= '0;
            r_tenure_cnt <= '0;
         end else begin
            r_idle_cnt <= w_own_strobe ? '0 : (r_idle_cnt + c_one);
            if (r_tenure_cnt < c_tenure_max) begin
               r_tenure_cnt <= r_tenure_cnt + c_one;
            end
         end
      end
   end

   // Pass-through decode; IDLE falls through to the all-zero defaults.
   always_comb begin
      req0_rdata   = 8'h00;
      req0_valid   = 1'b0;
      req0_ready   = 1'b0;
      req1_rdata   = 8'h00;
      req1_valid   = 1'b0;
      req1_ready   = 1'b0;
      uart_rx_rden = 1'b0;
      uart_tx_wren = 1'b0;
      uart_tx_data = 8'h00;
      case (r_state)
         OWN0: begin
            req0_rdata   = uart_rx_data;
            req0_valid   = uart_rx_valid;
            req0_ready   = uart_tx_ready;
            uart_rx_rden = req0_rden & uart_rx_valid;
            uart_tx_wren = req0_wren & uart_tx_ready;
            uart_tx_data = req0_wren ? req0_wdata : 8'h00;
         end
         OWN1: begin
            req1_rdata   = uart_rx_data;
            req1_valid   = uart_rx_valid;
            req1_ready   = uart_tx_ready;
            uart_rx_rden = req1_rden & uart_rx_valid;
            uart_tx_wren = req1_wren & uart_tx_ready;
            uart_tx_data = req1_wren ? req1_wdata : 8'h00;
         end
         default: begin
            uart_tx_data = 8'h00;
         end
      endcase
   end

`ifdef SERIAL_ARB_STATS_EN
   logic [15:0] r_grant_count0;
   logic [15:0] r_grant_count1;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_grant_count0 <= 16'h0000;
         r_grant_count1 <= 16'h0000;
      end else begin
         if (w_grant0) begin
            r_grant_count0 <= r_grant_count0 + 16'h0001;
         end
         if (w_grant1) begin
            r_grant_count1 <= r_grant_count1 + 16'h0001;
         end
      end
   end

   assign grant_count0 = r_grant_count0;
   assign grant_count1 = r_grant_count1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_arbiter
//  Purpose  : Directed bench for serial_arbiter with an ownership model
//             compared against every output on each falling clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_arbiter;

   localparam int c_IDLE_RELEASE = 4;
   localparam int c_MAX_TENURE   = 64;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       req0_rden = 1'b0, req0_wren = 1'b0;
   logic [7:0] req0_wdata = 8'h00;
   logic [7:0] req0_rdata;
   logic       req0_valid, req0_ready;
   logic       req1_rden = 1'b0, req1_wren = 1'b0;
   logic [7:0] req1_wdata = 8'h00;
   logic [7:0] req1_rdata;
   logic       req1_valid, req1_ready;
   logic [7:0] uart_rx_data = 8'h00;
   logic       uart_rx_valid = 1'b0;
   logic       uart_rx_rden;
   logic       uart_tx_ready = 1'b0;
   logic [7:0] uart_tx_data;
   logic       uart_tx_wren;
`ifdef SERIAL_ARB_STATS_EN
   logic [15:0] grant_count0, grant_count1;
`endif

   serial_arbiter #(
      .IDLE_RELEASE (c_IDLE_RELEASE),
      .MAX_TENURE   (c_MAX_TENURE),
      .CNT_W        (8)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .req0_rden     (req0_rden),
      .req0_wren     (req0_wren),
      .req0_wdata    (req0_wdata),
      .req0_rdata    (req0_rdata),
      .req0_valid    (req0_valid),
      .req0_ready    (req0_ready),
      .req1_rden     (req1_rden),
      .req1_wren     (req1_wren),
      .req1_wdata    (req1_wdata),
      .req1_rdata    (req1_rdata),
      .req1_valid    (req1_valid),
      .req1_ready    (req1_ready),
      .uart_rx_data  (uart_rx_data),
      .uart_rx_valid (uart_rx_valid),
      .uart_rx_rden  (uart_rx_rden),
      .uart_tx_ready (uart_tx_ready),
      .uart_tx_data  (uart_tx_data),
      .uart_tx_wren  (uart_tx_wren)
`ifdef SERIAL_ARB_STATS_EN
      ,
      .grant_count0  (grant_count0),
      .grant_count1  (grant_count1)
`endif
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: owner is -1 (none), 0 or 1; quiet = strobe-free owner cycles so
   // far, held = owner cycles completed in the current burst.
   int m_owner = -1, m_last = 1, m_quiet = 0, m_held = 0, m_gc0 = 0, m_gc1 = 0;
   int m_nx_owner = -1, m_nx_last = 1, m_nx_quiet = 0, m_nx_held = 0;
   int m_nx_gc0 = 0, m_nx_gc1 = 0;

   always @(negedge clock) begin : p_compare
      logic r0, r1, own0, own1, strobe, other;
      r0   = req0_rden | req0_wren;
      r1   = req1_rden | req1_wren;
      own0 = (m_owner == 0);
      own1 = (m_owner == 1);

      chk("req0_rdata", 32'(req0_rdata), 32'(own0 ? uart_rx_data : 8'h00));
      chk("req0_valid", 32'(req0_valid), 32'(own0 & uart_rx_valid));
      chk("req0_ready", 32'(req0_ready), 32'(own0 & uart_tx_ready));
      chk("req1_rdata", 32'(req1_rdata), 32'(own1 ? uart_rx_data : 8'h00));
      chk("req1_valid", 32'(req1_valid), 32'(own1 & uart_rx_valid));
      chk("req1_ready", 32'(req1_ready), 32'(own1 & uart_tx_ready));
      chk("uart_rx_rden", 32'(uart_rx_rden),
          32'(((own0 & req0_rden) | (own1 & req1_rden)) & uart_rx_valid));
      chk("uart_tx_wren", 32'(uart_tx_wren),
          32'(((own0 & req0_wren) | (own1 & req1_wren)) & uart_tx_ready));
      chk("uart_tx_data", 32'(uart_tx_data),
          32'((own0 && req0_wren) ? req0_wdata : ((own1 && req1_wren) ? req1_wdata : 8'h00)));
`ifdef SERIAL_ARB_STATS_EN
      chk("grant_count0", 32'(grant_count0), 32'(m_gc0 % 65536));
      chk("grant_count1", 32'(grant_count1), 32'(m_gc1 % 65536));
`endif

      m_nx_quiet = 0;
      m_nx_held  = 0;
      if (m_owner < 0) begin
         if (r0 && r1)  m_nx_owner = 1 - m_last;
         else if (r0)   m_nx_owner = 0;
         else if (r1)   m_nx_owner = 1;
         else           m_nx_owner = -1;
      end else begin
         strobe = (m_owner == 0) ? r0 : r1;
         other  = (m_owner == 0) ? r1 : r0;
         if ((!strobe && (m_quiet + 1 >= c_IDLE_RELEASE)) ||
             (other && (m_held + 1 >= c_MAX_TENURE))) begin
            m_nx_owner = other ? 1 - m_owner : -1;
         end else begin
            m_nx_owner = m_owner;
            m_nx_quiet = strobe ? 0 : m_quiet + 1;
            m_nx_held  = m_held + 1;
         end
      end
      m_nx_gc0  = m_gc0 + (((m_nx_owner == 0) && (m_owner != 0)) ? 1 : 0);
      m_nx_gc1  = m_gc1 + (((m_nx_owner == 1) && (m_owner != 1)) ? 1 : 0);
      m_nx_last = (m_nx_owner >= 0 && m_nx_owner != m_owner) ? m_nx_owner : m_last;
   end

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_owner <= -1;
         m_last  <= 1;
         m_quiet <= 0;
         m_held  <= 0;
         m_gc0   <= 0;
         m_gc1   <= 0;
      end else begin
         m_owner <= m_nx_owner;
         m_last  <= m_nx_last;
         m_quiet <= m_nx_quiet;
         m_held  <= m_nx_held;
         m_gc0   <= m_nx_gc0;
         m_gc1   <= m_nx_gc1;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic strobes_off();
      req0_rden = 1'b0; req0_wren = 1'b0;
      req1_rden = 1'b0; req1_wren = 1'b0;
   endtask

   initial begin
      // Reset, then ten quiet cycles (model compare covers all-zero outputs).
      cyc(3);
      reset = 1'b1;
      uart_rx_valid = 1'b1;
      uart_tx_ready = 1'b1;
      cyc(10);
      chk("reset_model_idle", 32'(m_owner), 32'hFFFF_FFFF);
      chk("reset_req0_valid", 32'(req0_valid), 32'd0);

      // Single writer on port 0: no push in the request cycle, push next.
      req0_wren = 1'b1; req0_wdata = 8'h41;
      @(negedge clock);
      chk("c1_no_push", 32'(uart_tx_wren), 32'd0);
      cyc(1);
      @(negedge clock);
      chk("c2_push", 32'(uart_tx_wren), 32'd1);
      chk("c2_data", 32'(uart_tx_data), 32'h41);
      chk("c2_p1_ready", 32'(req1_ready), 32'd0);
      cyc(1);
      strobes_off();
      cyc(6);

      // Reset pulse, then simultaneous requests: port 0 first, port 1 next.
      reset = 1'b0;
      cyc(1);
      reset = 1'b1;
      uart_rx_data = 8'h33;
      req0_rden = 1'b1; req1_rden = 1'b1;
      cyc(1);
      @(negedge clock);
      chk("tie_p0_valid", 32'(req0_valid), 32'd1);
      chk("tie_p1_valid", 32'(req1_valid), 32'd0);
      cyc(1);
      strobes_off();
      cyc(4);
      @(negedge clock);
      chk("released_p0", 32'(req0_valid), 32'd0);
      req0_rden = 1'b1; req1_rden = 1'b1;
      cyc(1);
      @(negedge clock);
      chk("tie2_p1_valid", 32'(req1_valid), 32'd1);
      chk("tie2_p0_valid", 32'(req0_valid), 32'd0);
      chk("model_tie2", 32'(m_owner), 32'd1);
      cyc(1);
      strobes_off();
      cyc(4);

      // Tenure limit: port 0 busy every cycle, port 1 waiting.
      uart_rx_data = 8'h5A;
      req0_rden = 1'b1; req1_rden = 1'b1;
      cyc(64);
      @(negedge clock);
      chk("ten64_p0_valid", 32'(req0_valid), 32'd1);
      chk("ten64_p1_rdata", 32'(req1_rdata), 32'd0);
      cyc(1);
      @(negedge clock);
      chk("ten65_p1_rdata", 32'(req1_rdata), 32'h5A);
      chk("ten65_rx_rden", 32'(uart_rx_rden), 32'd1);
      chk("ten65_p0_valid", 32'(req0_valid), 32'd0);
      chk("model_ten65", 32'(m_owner), 32'd1);

      // Owner pop on empty FIFO is masked, then four quiet cycles release.
      cyc(1);
      req0_rden = 1'b0;
      uart_rx_valid = 1'b0;
      @(negedge clock);
      chk("empty_rx_rden", 32'(uart_rx_rden), 32'd0);
      cyc(1);
      strobes_off();
      uart_rx_valid = 1'b1;
      cyc(3);
      @(negedge clock);
      chk("quiet4_p1_valid", 32'(req1_valid), 32'd1);
      cyc(1);
      @(negedge clock);
      chk("quiet_idle_p1", 32'(req1_valid), 32'd0);

      // Port 1 burst interrupted by reset.
      req1_wren = 1'b1; req1_wdata = 8'hC3;
      cyc(1);
      @(negedge clock);
      chk("own1_push", 32'(uart_tx_wren), 32'd1);
      chk("own1_data", 32'(uart_tx_data), 32'hC3);
      cyc(1);
      reset = 1'b0;
      @(negedge clock);
      chk("rst_mid_push", 32'(uart_tx_wren), 32'd0);
      chk("rst_mid_ready", 32'(req1_ready), 32'd0);
`ifdef SERIAL_ARB_STATS_EN
      chk("rst_grant_count1", 32'(grant_count1), 32'd0);
`endif
      cyc(1);
      strobes_off();
      reset = 1'b1;
      cyc(5);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
